// File: rtl/fft_magnitude_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fft_magnitude_buffer
// Description : Stores FFT bin power (re^2+im^2) for one half-spectrum in a ping-pong RAM
// Revision    : 1.0 - initial release
// ============================================================================
module fft_magnitude_buffer #(
    parameter int FFT_WIDTH = 16,
    parameter int FFT_SIZE  = 1024,
    parameter int MAG_WIDTH = 16,
    parameter int MAG_SHIFT = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [2*FFT_WIDTH-1:0]          s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    input  logic [$clog2(FFT_SIZE/2)-1:0]   rd_addr,
    output logic [MAG_WIDTH-1:0]            rd_data,
    output logic                            frame_ready,
    output logic                            sync_error
);

    localparam int c_idx_w  = $clog2(FFT_SIZE);
    localparam int c_addr_w = c_idx_w - 1;
    localparam int c_prod_w = 2 * FFT_WIDTH;
    localparam int c_sum_w  = c_prod_w + 1;
    localparam logic [c_idx_w-1:0] c_last_bin = c_idx_w'(FFT_SIZE - 1);

    logic                        r_tready;
    logic [c_idx_w-1:0]          r_bin_cnt;
    logic                        r_bank_sel;

    logic                        w_accept;
    logic                        w_at_end;
    logic                        w_good_end;
    logic                        w_frame_err;

    logic                        r_s1_valid;
    logic signed [FFT_WIDTH-1:0] r_s1_re;
    logic signed [FFT_WIDTH-1:0] r_s1_im;
    logic [c_idx_w-1:0]          r_s1_idx;
    logic                        r_s1_swap;
    logic                        r_s1_err;

    logic signed [c_prod_w-1:0]  w_re_ext;
    logic signed [c_prod_w-1:0]  w_im_ext;

    logic                        r_s2_valid;
    logic [c_prod_w-1:0]         r_s2_pre;
    logic [c_prod_w-1:0]         r_s2_pim;
    logic [c_idx_w-1:0]          r_s2_idx;
    logic                        r_s2_swap;
    logic                        r_s2_err;

    logic [c_sum_w-1:0]          w_sum;
    logic [c_sum_w-1:0]          w_scaled;
    logic [MAG_WIDTH-1:0]        w_mag;

    logic                        r_s3_valid;
    logic [MAG_WIDTH-1:0]        r_s3_mag;
    logic [c_idx_w-1:0]          r_s3_idx;

    logic [MAG_WIDTH-1:0]        r_mem [0:FFT_SIZE-1];

    assign s_axis_tready = r_tready;
    assign w_accept      = s_axis_tvalid & r_tready;
    assign w_at_end      = (r_bin_cnt == c_last_bin);
    assign w_good_end    = s_axis_tlast & w_at_end;
    // Any framing error also ends the frame, so a single acceptance-time flag
    // is enough to keep a damaged frame from being published.
    assign w_frame_err   = s_axis_tlast ^ w_at_end;

    // ------------------------------------------------------------------
    // Stage 1: acceptance, bin counting, operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tready   <= 1'b0;
            r_bin_cnt  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_tready   <= 1'b1;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                if (s_axis_tlast || w_at_end)
                    r_bin_cnt <= '0;
                else
                    r_bin_cnt <= r_bin_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_re   <= s_axis_tdata[FFT_WIDTH-1:0];
            r_s1_im   <= s_axis_tdata[2*FFT_WIDTH-1:FFT_WIDTH];
            r_s1_idx  <= r_bin_cnt;
            r_s1_swap <= w_good_end;
            r_s1_err  <= w_frame_err;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: squares (full-width, so (-2^(W-1))^2 is exact)
    // ------------------------------------------------------------------
    assign w_re_ext = {{FFT_WIDTH{r_s1_re[FFT_WIDTH-1]}}, r_s1_re};
    assign w_im_ext = {{FFT_WIDTH{r_s1_im[FFT_WIDTH-1]}}, r_s1_im};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        r_s2_pre  <= w_re_ext * w_re_ext;
        r_s2_pim  <= w_im_ext * w_im_ext;
        r_s2_idx  <= r_s1_idx;
        r_s2_swap <= r_s1_swap;
        r_s2_err  <= r_s1_err;
    end

    // ------------------------------------------------------------------
    // Stage 3: sum, scale, saturate; frame status aligned with the write
    // ------------------------------------------------------------------
    assign w_sum    = {1'b0, r_s2_pre} + {1'b0, r_s2_pim};
    assign w_scaled = w_sum >> MAG_SHIFT;

    generate
        if (c_sum_w > MAG_WIDTH) begin : g_sat
            assign w_mag = (|w_scaled[c_sum_w-1:MAG_WIDTH]) ? {MAG_WIDTH{1'b1}}
                                                             : w_scaled[MAG_WIDTH-1:0];
        end else begin : g_nosat
            assign w_mag = MAG_WIDTH'(w_scaled);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s3_valid  <= 1'b0;
            frame_ready <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            r_s3_valid  <= r_s2_valid;
            frame_ready <= r_s2_valid & r_s2_swap;
            sync_error  <= r_s2_valid & r_s2_err;
        end
    end

    always_ff @(posedge clk) begin
        r_s3_mag <= w_mag;
        r_s3_idx <= r_s2_idx;
    end

    // frame_ready marks the swap cycle; the new bank is visible from the next one
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bank_sel <= 1'b0;
        end else if (frame_ready) begin
            r_bank_sel <= ~r_bank_sel;
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong storage: back bank written, front bank read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst && r_s3_valid && !r_s3_idx[c_idx_w-1]) begin
            r_mem[{~r_bank_sel, r_s3_idx[c_addr_w-1:0]}] <= r_s3_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= r_mem[{r_bank_sel, rd_addr}];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_magnitude_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_magnitude_buffer
// Description : Directed bench; dut_a uses MAG_SHIFT=0, dut_b the default 15
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_magnitude_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic [8:0]  rd_addr;
    logic        tready_a, tready_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        fr_a, fr_b, se_a, se_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int fr_a_cnt = 0, fr_b_cnt = 0, se_a_cnt = 0;
    int fr_a_cyc = 0, se_a_cyc = 0;

    fft_magnitude_buffer #(.FFT_WIDTH(16), .FFT_SIZE(1024), .MAG_WIDTH(16), .MAG_SHIFT(0)) dut_a (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tready(tready_a), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .frame_ready(fr_a), .sync_error(se_a));

    fft_magnitude_buffer #(.FFT_WIDTH(16), .FFT_SIZE(1024), .MAG_WIDTH(16), .MAG_SHIFT(15)) dut_b (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tready(tready_b), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .frame_ready(fr_b), .sync_error(se_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fr_a === 1'b1) begin
            fr_a_cnt <= fr_a_cnt + 1;
            fr_a_cyc <= cyc;
        end
        if (fr_b === 1'b1) fr_b_cnt <= fr_b_cnt + 1;
        if (se_a === 1'b1) begin
            se_a_cnt <= se_a_cnt + 1;
            se_a_cyc <= cyc;
        end
    end

    task automatic beat(input int re, input int im, input logic last);
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = {im[15:0], re[15:0]};
        tlast  = last;
        hs_cyc = cyc;
    endtask

    // Junk data and tlast while invalid must be ignored by the DUT
    task automatic idle();
        @(negedge clk);
        tvalid = 1'b0;
        tdata  = $urandom;
        tlast  = 1'($urandom_range(0, 1));
    endtask

    task automatic read_bin(input int a);
        @(negedge clk);
        rd_addr = a[8:0];
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0; rd_addr = '0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({tready_a, tready_b, fr_a, fr_b, se_a, se_b} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got tready/fr/se %b expected 000000", i,
                         {tready_a, tready_b, fr_a, fr_b, se_a, se_b});
            end
        end
        checks++;
        if (rd_data_a !== 16'd0) begin
            errors++;
            $display("FAIL reset_rd_data: got %0d expected 0", rd_data_a);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tready_a, tready_b, fr_a, se_a} !== 4'b1100) begin
            errors++;
            $display("FAIL release_tready: got tready_a,b,fr,se %b expected 1100",
                     {tready_a, tready_b, fr_a, se_a});
        end
    endtask

    task automatic test_known_bins();
        int f0, fb0, t;
        f0 = fr_a_cnt; fb0 = fr_b_cnt;
        for (int k = 0; k < 1024; k++) beat(3, 4, k == 1023);
        t = hs_cyc;
        repeat (6) idle();
        checks++;
        if (fr_a_cnt != f0 + 1 || fr_b_cnt != fb0 + 1) begin
            errors++;
            $display("FAIL known_frame_count: got %0d/%0d expected %0d/%0d",
                     fr_a_cnt - f0, fr_b_cnt - fb0, 1, 1);
        end
        checks++;
        if (fr_a_cyc - t != 3) begin
            errors++;
            $display("FAIL known_frame_latency: got %0d expected 3", fr_a_cyc - t);
        end
        for (int a = 0; a < 512; a++) begin
            read_bin(a);
            checks++;
            if (rd_data_a !== 16'd25) begin
                errors++;
                $display("FAIL known_bin addr %0d: got %0d expected 25", a, rd_data_a);
            end
        end
        checks++;
        if (rd_data_b !== 16'd0) begin
            errors++;
            $display("FAIL known_bin_shift15: got %0d expected 0", rd_data_b);
        end
    endtask

    task automatic test_saturation();
        int f0;
        f0 = fr_b_cnt;
        for (int k = 0; k < 1024; k++) begin
            if (k == 5) beat(-32768, -32768, 1'b0);
            else        beat(0, 0, k == 1023);
        end
        repeat (6) idle();
        checks++;
        if (fr_b_cnt != f0 + 1) begin
            errors++;
            $display("FAIL sat_frame_count: got %0d expected 1", fr_b_cnt - f0);
        end
        for (int a = 0; a < 512; a++) begin
            int exp_b;
            read_bin(a);
            exp_b = (a == 5) ? 65535 : 0;
            checks++;
            if (rd_data_b !== 16'(exp_b)) begin
                errors++;
                $display("FAIL sat_bin addr %0d: got %0d expected %0d", a, rd_data_b, exp_b);
            end
            if (a == 5) begin
                checks++;
                if (rd_data_a !== 16'd65535) begin
                    errors++;
                    $display("FAIL sat_bin_shift0: got %0d expected 65535", rd_data_a);
                end
            end
        end
    endtask

    task automatic test_upper_half();
        for (int k = 0; k < 1024; k++) beat(k, 0, k == 1023);
        repeat (6) idle();
        for (int a = 0; a < 512; a++) begin
            int exp_a, exp_b;
            read_bin(a);
            exp_a = (a < 256) ? a * a : 65535;
            exp_b = (a * a) >> 15;
            checks++;
            if (rd_data_a !== 16'(exp_a) || rd_data_b !== 16'(exp_b)) begin
                errors++;
                $display("FAIL upper_half addr %0d: got %0d/%0d expected %0d/%0d",
                         a, rd_data_a, rd_data_b, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_early_tlast();
        int s0, f0, t;
        s0 = se_a_cnt; f0 = fr_a_cnt;
        for (int k = 0; k <= 700; k++) beat(1, 1, k == 700);
        t = hs_cyc;
        repeat (6) idle();
        checks++;
        if (se_a_cnt != s0 + 1 || se_a_cyc - t != 3) begin
            errors++;
            $display("FAIL early_sync_error: got count %0d delay %0d expected count 1 delay 3",
                     se_a_cnt - s0, se_a_cyc - t);
        end
        checks++;
        if (fr_a_cnt != f0) begin
            errors++;
            $display("FAIL early_no_publish: got %0d frames expected 0", fr_a_cnt - f0);
        end
        read_bin(300);
        checks++;
        if (rd_data_a !== 16'd65535) begin
            errors++;
            $display("FAIL early_old_frame addr 300: got %0d expected 65535", rd_data_a);
        end
        read_bin(10);
        checks++;
        if (rd_data_a !== 16'd100) begin
            errors++;
            $display("FAIL early_old_frame addr 10: got %0d expected 100", rd_data_a);
        end
        // rd_addr stays at 10 across the swap to observe the switchover cycle
        for (int k = 0; k < 1024; k++) beat(2, 0, k == 1023);
        idle(); idle(); idle();
        checks++;
        if (fr_a !== 1'b1) begin
            errors++;
            $display("FAIL swap_frame_ready: got %b expected 1", fr_a);
        end
        idle();
        checks++;
        if (rd_data_a !== 16'd100) begin
            errors++;
            $display("FAIL swap_cycle_read: got %0d expected 100", rd_data_a);
        end
        idle();
        checks++;
        if (rd_data_a !== 16'd4) begin
            errors++;
            $display("FAIL post_swap_read: got %0d expected 4", rd_data_a);
        end
        read_bin(511);
        checks++;
        if (rd_data_a !== 16'd4 || se_a_cnt != s0 + 1) begin
            errors++;
            $display("FAIL good_after_early addr 511: got %0d errs %0d expected 4 errs 1",
                     rd_data_a, se_a_cnt - s0);
        end
    endtask

    task automatic test_back_to_back();
        int s0, f0, t;
        s0 = se_a_cnt; f0 = fr_a_cnt;
        for (int k = 0; k < 1024; k++) beat(1, 0, 1'b0);
        t = hs_cyc;
        for (int k = 0; k < 1024; k++) begin
            if ($urandom_range(0, 3) == 0) idle();
            beat(5, 0, k == 1023);
        end
        for (int k = 0; k < 1024; k++) begin
            if (k != 0 && $urandom_range(0, 3) == 0) idle();
            beat(k % 100, 1, k == 1023);
        end
        repeat (6) idle();
        checks++;
        if (se_a_cnt != s0 + 1 || se_a_cyc - t != 3) begin
            errors++;
            $display("FAIL missing_tlast_error: got count %0d delay %0d expected count 1 delay 3",
                     se_a_cnt - s0, se_a_cyc - t);
        end
        checks++;
        if (fr_a_cnt != f0 + 2) begin
            errors++;
            $display("FAIL b2b_frame_count: got %0d expected 2", fr_a_cnt - f0);
        end
        for (int a = 0; a < 512; a++) begin
            int exp_a;
            read_bin(a);
            exp_a = (a % 100) * (a % 100) + 1;
            checks++;
            if (rd_data_a !== 16'(exp_a)) begin
                errors++;
                $display("FAIL b2b_bin addr %0d: got %0d expected %0d", a, rd_data_a, exp_a);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known_bins();
        test_saturation();
        test_upper_half();
        test_early_tlast();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
